decode_issue_buffer: RTL
========================

DECODE_ISSUE_BUFFER -- requirements
Module: decode_issue_buffer

Interface
REQ-001 Parameter FETCH_W, default 2, instructions delivered per fetch beat.
REQ-002 Parameter ISSUE_W, default 2, maximum instructions presented to decode per cycle; legal range 1..FETCH_W*2.
REQ-003 Parameter DEPTH, default 8, buffer entries; power of two, DEPTH >= 2*FETCH_W.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 resetn  input  1  reset, synchronous and active-low.
REQ-006 flush  input  1  discard all buffered entries (redirect/exception).
REQ-007 in_valid  input  FETCH_W  per-slot valid; slot 0 oldest; set bits contiguous from bit 0.
REQ-008 in_pc  input  FETCH_W x 32  per-slot PC.
REQ-009 in_instr  input  FETCH_W x 32  per-slot raw instruction.
REQ-010 in_jump  input  FETCH_W  per-slot flag: instruction is a branch/jump that owns a delay slot.
REQ-011 in_ready  output  1  buffer accepts the current fetch beat.
REQ-012 out_valid  output  ISSUE_W  per-slot issue valid; slot 0 oldest; contiguous from bit 0.
REQ-013 out_pc, out_instr  output  ISSUE_W x 32 each  issued PC and raw instruction.
REQ-014 out_is_slot  output  ISSUE_W  slot is the delay slot of the instruction in the preceding issue slot.
REQ-015 out_take  input  clog2(ISSUE_W+1)  number of presented slots consumed by decode this cycle.
REQ-016 count  output  clog2(DEPTH+1)  current occupancy.

Function
REQ-017 Storage: circular buffer of DEPTH entries {pc, instr, jump}; head and tail pointers wrap modulo DEPTH.
REQ-018 in_ready = (DEPTH - count) >= FETCH_W, computed from registered count only (not from same-cycle dequeue).
REQ-019 Enqueue when in_ready and in_valid != 0: the popcount(in_valid) valid slots are written in slot order at tail; tail and count advance by that popcount.
REQ-020 In-beat with in_ready = 0 is not written; upstream holds it (no data loss, no partial write).
REQ-021 Candidate issue n = min(count, ISSUE_W) oldest entries, presented combinationally from registered state.
REQ-022 Delay-slot pairing: a jump entry is presented only if its following entry is also presented in the same cycle; otherwise presentation stops before the jump (n reduced accordingly).
REQ-023 Consequently a jump never occupies issue slot ISSUE_W-1, and a jump as youngest buffered entry is held until its delay slot arrives.
REQ-024 out_is_slot[i] = 1 iff i > 0, out_valid[i], and entry in slot i-1 has jump = 1; out_is_slot[0] always 0.
REQ-025 out_take <= popcount(out_valid) is required of the consumer; out_take shall never split a jump from its delay slot (violation is a consumer error; behaviour unspecified).
REQ-026 Dequeue: head advances and count decreases by out_take each cycle.
REQ-027 Simultaneous enqueue and dequeue: count_next = count + enq - out_take; both pointers update in the same edge.
REQ-028 Empty (count = 0): out_valid = 0; same-cycle input is not forwarded (minimum latency one cycle, enqueue to presentation).
REQ-029 Full: in_ready = 0 until count <= DEPTH - FETCH_W; dequeue in the full cycle does not raise in_ready that cycle.
REQ-030 flush: next edge sets head = tail = 0, count = 0; overrides same-cycle enqueue and dequeue; in_ready is held 1 during flush.
REQ-031 out_pc, out_instr for invalid slots are don't-care; out_is_slot for invalid slots is 0.

Reset
REQ-032 resetn = 0 at a clock edge: head = 0, tail = 0, count = 0; after that edge out_valid = 0, out_is_slot = 0, in_ready = 1.
REQ-033 Reset asserted mid-operation discards all entries; no entry issues after reset until re-enqueued.
REQ-034 Storage array contents are not reset.

Verification
REQ-035 Defaults; enqueue {pc 0x100 add, 0x104 sub}; next cycle out_valid = 2'b11, out_is_slot = 2'b00; out_take = 2 -> count 0.
REQ-036 Enqueue {0x200 beq(jump), 0x204 nop} -> out_valid = 2'b11, out_is_slot = 2'b10; enqueue {0x300 j, nothing in slot 1} -> out_valid = 0 until 0x304 is enqueued, then 2'b11 with out_is_slot = 2'b10.
REQ-037 Buffer holds {0x400 add, 0x404 jal, 0x408 nop} -> out_valid = 2'b01 (jal withheld); after out_take = 1, out_valid = 2'b11, out_is_slot = 2'b10.
REQ-038 out_take = 0; enqueue 4 full beats -> count = 8, in_ready = 0; fifth beat held; out_take = 2 -> in_ready = 1 next cycle; pointers wrap, PC order preserved across wrap.
REQ-039 count = 5 with flush and in_valid = 2'b11 same cycle -> next cycle count = 0, out_valid = 0.
REQ-040 resetn = 0 with count = 6 -> next cycle count = 0, out_valid = 0, in_ready = 1.

Source files
------------

// File: rtl/decode_issue_buffer.sv
// Decode issue buffer: a circular queue between fetch and decode.
// Fetch beats of up to FETCH_W instructions are written at the tail. Up to
// ISSUE_W of the oldest entries are presented to decode from the head, and a
// branch/jump is never presented without its delay slot.
//
// Handshake: a fetch beat transfers on a rising edge when
// in_ready && |in_valid && !flush. in_ready depends only on the registered
// occupancy (and is forced high while flush is asserted). Decode consumes the
// out_take oldest presented slots on each rising edge. out_take must not
// exceed the number of presented slots and must not split a jump from its
// delay slot.
module decode_issue_buffer #(
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             flush,
  input  logic [FETCH_W-1:0]               in_valid,
  input  logic [FETCH_W-1:0][31:0]         in_pc,
  input  logic [FETCH_W-1:0][31:0]         in_instr,
  input  logic [FETCH_W-1:0]               in_jump,
  output logic                             in_ready,
  output logic [ISSUE_W-1:0]               out_valid,
  output logic [ISSUE_W-1:0][31:0]         out_pc,
  output logic [ISSUE_W-1:0][31:0]         out_instr,
  output logic [ISSUE_W-1:0]               out_is_slot,
  input  logic [$clog2(ISSUE_W+1)-1:0]     out_take,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; contents are intentionally left unreset.
  logic [31:0]      pc_mem    [DEPTH];
  logic [31:0]      instr_mem [DEPTH];
  logic [DEPTH-1:0] jump_mem;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0] enq_cnt;
  logic          room_ok;
  logic          accept;

  logic [CW-1:0] n_avail;
  logic [CW-1:0] n_pres;
  logic [PW-1:0] cand_idx  [ISSUE_W];
  logic [ISSUE_W-1:0] cand_jump;

  // Number of valid slots in the incoming beat (valid bits are contiguous).
  always_comb begin
    enq_cnt = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      enq_cnt = enq_cnt + CW'(in_valid[s]);
    end
  end

  // Room for a whole beat is judged from registered occupancy only, so a
  // dequeue in a full cycle cannot raise in_ready in that same cycle.
  assign room_ok  = (count_q <= CW'(DEPTH - FETCH_W));
  assign in_ready = flush | room_ok;
  assign accept   = resetn & room_ok & (|in_valid) & ~flush;
  assign count    = count_q;

  // Present the oldest entries; the presented run ends at the last non-jump
  // among the candidates, so every presented jump has its delay slot with it.
  always_comb begin
    n_avail     = (count_q > CW'(ISSUE_W)) ? CW'(ISSUE_W) : count_q;
    n_pres      = '0;
    cand_jump   = '0;
    out_valid   = '0;
    out_is_slot = '0;
    out_pc      = '0;
    out_instr   = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      cand_idx[i]  = head_q + PW'(i);
      cand_jump[i] = jump_mem[cand_idx[i]];
      out_pc[i]    = pc_mem[cand_idx[i]];
      out_instr[i] = instr_mem[cand_idx[i]];
      if ((CW'(i) < n_avail) && !cand_jump[i]) begin
        n_pres = CW'(i + 1);
      end
    end
    for (int i = 0; i < ISSUE_W; i++) begin
      out_valid[i] = (CW'(i) < n_pres);
    end
    for (int i = 1; i < ISSUE_W; i++) begin
      out_is_slot[i] = out_valid[i] & cand_jump[i-1];
    end
  end

  // Pointer and occupancy next state; flush wins over enqueue and dequeue.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept) begin
        tail_d = tail_q + PW'(enq_cnt);
      end
      head_d  = head_q + PW'(out_take);
      count_d = count_q + (accept ? enq_cnt : CW'(0)) - CW'(out_take);
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Write the valid slots of an accepted beat in slot order at the tail.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int s = 0; s < FETCH_W; s++) begin
        if (in_valid[s]) begin
          pc_mem[tail_q + PW'(s)]    <= in_pc[s];
          instr_mem[tail_q + PW'(s)] <= in_instr[s];
          jump_mem[tail_q + PW'(s)]  <= in_jump[s];
        end
      end
    end
  end

endmodule
